icb_sram_slave: RTL and testbench

ICB_SRAM_SLAVE -- requirements
Module: icb_sram_slave

---
 rtl/icb_sram_pkg.sv | 11 +
 rtl/icb_sram_rsp_fifo.sv | 46 ++++
 rtl/icb_sram_slave.sv | 103 ++++++++++
 tb/tb_icb_sram_slave.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/icb_sram_pkg.sv
// Shared constants and response payload type for the ICB SRAM slave.
// The optional ICB_SRAM_ADDR_CHK_EN range check lives in icb_sram_slave.
package icb_sram_pkg;
    localparam int unsigned ICB_AW = 32;
    localparam int unsigned ICB_DW = 32;

    typedef struct packed {
        logic              err;
        logic [ICB_DW-1:0] rdata;
    } icb_rsp_t;
endpackage

// File: rtl/icb_sram_rsp_fifo.sv
// In-order response queue; depth need not be a power of two (pointers wrap explicitly).
module icb_sram_rsp_fifo
    import icb_sram_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter type         T     = icb_rsp_t
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic push_i,
    input  T     push_data_i,
    input  logic pop_i,
    output T     head_o,
    output logic nempty_o
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    T               mem_q [DEPTH];
    logic [PW-1:0]  wptr_q, rptr_q;
    logic [CW-1:0]  cnt_q;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_i) wptr_q <= nxt(wptr_q);
            if (pop_i)  rptr_q <= nxt(rptr_q);
            if (push_i && !pop_i)      cnt_q <= cnt_q + CW'(1);
            else if (!push_i && pop_i) cnt_q <= cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wptr_q] <= push_data_i;
    end

    assign head_o   = mem_q[rptr_q];
    assign nempty_o = (cnt_q != '0);
endmodule

// File: rtl/icb_sram_slave.sv
// ICB-attached single-port SRAM with fixed-latency, in-order responses.
// Define ICB_SRAM_ADDR_CHK_EN to flag out-of-window accesses instead of aliasing.
module icb_sram_slave
    import icb_sram_pkg::*;
#(
    parameter int unsigned    AW        = ICB_AW,
    parameter int unsigned    DW        = ICB_DW,
    parameter int unsigned    DEPTH     = 1024,
    parameter logic [AW-1:0]  BASE_ADDR = 'h8000_0000,
    parameter int unsigned    RSP_LAT   = 1,
    parameter int unsigned    OSTD      = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            icb_cmd_valid,
    output logic            icb_cmd_ready,
    input  logic [AW-1:0]   icb_cmd_addr,
    input  logic            icb_cmd_read,
    input  logic [DW-1:0]   icb_cmd_wdata,
    input  logic [DW/8-1:0] icb_cmd_wmask,
    output logic            icb_rsp_valid,
    input  logic            icb_rsp_ready,
    output logic            icb_rsp_err,
    output logic [DW-1:0]   icb_rsp_rdata
);
    localparam int unsigned NB = DW / 8;
    localparam int unsigned BW = $clog2(NB);
    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(OSTD + 1);

    logic [DW-1:0]      mem_q [DEPTH];
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [RSP_LAT-1:0] vld_q;
    icb_rsp_t           dat_q [RSP_LAT];
    icb_rsp_t           rsp_new, fifo_head;
    logic               acc, rsp_hs, in_range, fifo_nempty;
    logic [AW-1:0]      off;
    logic [IW-1:0]      idx;

    // Ready depends only on registered occupancy, so a stalled consumer never reaches the command side.
    assign icb_cmd_ready = rst_n && (cnt_q < CW'(OSTD));
    assign acc           = icb_cmd_valid && icb_cmd_ready;
    assign rsp_hs        = icb_rsp_valid && icb_rsp_ready;

    assign off = icb_cmd_addr - BASE_ADDR;
    assign idx = IW'(off >> BW);
`ifdef ICB_SRAM_ADDR_CHK_EN
    assign in_range = (off < AW'(DEPTH * NB));
`else
    assign in_range = 1'b1;
`endif

    always_comb begin
        rsp_new     = '0;
        rsp_new.err = !in_range;
        if (icb_cmd_read && in_range) rsp_new.rdata = ICB_DW'(mem_q[idx]);
    end

    always_comb begin
        cnt_d = cnt_q;
        if (acc && !rsp_hs)      cnt_d = cnt_q + CW'(1);
        else if (!acc && rsp_hs) cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            vld_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            vld_q[0] <= acc;
            for (int i = 1; i < RSP_LAT; i++) vld_q[i] <= vld_q[i-1];
        end
    end

    // Payload pipe and array are left unreset; memory contents survive reset.
    always_ff @(posedge clk) begin
        dat_q[0] <= rsp_new;
        for (int i = 1; i < RSP_LAT; i++) dat_q[i] <= dat_q[i-1];
        if (acc && !icb_cmd_read && in_range) begin
            for (int b = 0; b < NB; b++) begin
                if (icb_cmd_wmask[b]) mem_q[idx][8*b +: 8] <= icb_cmd_wdata[8*b +: 8];
            end
        end
    end

    icb_sram_rsp_fifo #(
        .DEPTH (OSTD),
        .T     (icb_rsp_t)
    ) u_rsp_fifo (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .push_i      (vld_q[RSP_LAT-1]),
        .push_data_i (dat_q[RSP_LAT-1]),
        .pop_i       (rsp_hs),
        .head_o      (fifo_head),
        .nempty_o    (fifo_nempty)
    );

    assign icb_rsp_valid = rst_n && fifo_nempty;
    assign icb_rsp_err   = icb_rsp_valid && fifo_head.err;
    assign icb_rsp_rdata = icb_rsp_valid ? DW'(fifo_head.rdata) : '0;
endmodule

// File: tb/tb_icb_sram_slave.sv
// Table-driven bench with a response scoreboard for icb_sram_slave.
module tb_icb_sram_slave;
    localparam int LAT = 1;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_read = 1'b0, rsp_ready = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic [3:0]  cmd_wmask = '0;
    logic        cmd_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    always #5 clk = ~clk;

    icb_sram_slave #(.AW(32), .DW(32), .DEPTH(1024), .BASE_ADDR(32'h8000_0000),
                     .RSP_LAT(LAT), .OSTD(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .icb_cmd_valid (cmd_valid),
        .icb_cmd_ready (cmd_ready),
        .icb_cmd_addr  (cmd_addr),
        .icb_cmd_read  (cmd_read),
        .icb_cmd_wdata (cmd_wdata),
        .icb_cmd_wmask (cmd_wmask),
        .icb_rsp_valid (rsp_valid),
        .icb_rsp_ready (rsp_ready),
        .icb_rsp_err   (rsp_err),
        .icb_rsp_rdata (rsp_rdata)
    );

    typedef struct {
        bit          rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        bit          err;
        logic [31:0] rdata;
    } vec_t;

    typedef struct {
        bit          err;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    vec_t vecs [15];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Handshake predicted at the negedge preceding the edge that consumes it.
    always @(negedge clk) begin
        exp_t e;
        if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_rsp: got %h, expected no response", rsp_rdata);
            end else begin
                e = sb.pop_front();
                chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
                chk("rsp_rdata", rsp_rdata, e.rdata);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit rd, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] m, input bit err, input logic [31:0] rdata);
        int n;
        n = 0;
        cmd_valid = 1'b1; cmd_read = rd; cmd_addr = a; cmd_wdata = wd; cmd_wmask = m;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (cmd_ready !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL cmd_timeout: ready %b, expected 1", cmd_ready);
        end else begin
            sb.push_back('{err, rdata});
        end
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            step();
            n++;
        end
        chk("drain_pending", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vecs[0]  = '{1'b0, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 32'h8000_0010, 32'h0,         4'h0, 1'b0, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b0, 32'h8000_0010, 32'h0000_00AA, 4'h1, 1'b0, 32'h0};
        vecs[3]  = '{1'b1, 32'h8000_0010, 32'h0,         4'h0, 1'b0, 32'hDEAD_BEAA};
        vecs[4]  = '{1'b0, 32'h8000_0014, 32'h1122_3344, 4'hF, 1'b0, 32'h0};
        vecs[5]  = '{1'b0, 32'h8000_0014, 32'hAABB_CCDD, 4'hA, 1'b0, 32'h0};
        vecs[6]  = '{1'b1, 32'h8000_0014, 32'h0,         4'h0, 1'b0, 32'hAA22_CC44};
        vecs[7]  = '{1'b0, 32'h8000_0016, 32'hFFFF_FFFF, 4'h0, 1'b0, 32'h0};
        vecs[8]  = '{1'b1, 32'h8000_0017, 32'h0,         4'h0, 1'b0, 32'hAA22_CC44};
        vecs[9]  = '{1'b0, 32'h8000_0000, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h0};
`ifdef ICB_SRAM_ADDR_CHK_EN
        vecs[10] = '{1'b0, 32'h8000_1000, 32'h0BAD_F00D, 4'hF, 1'b1, 32'h0};
        vecs[11] = '{1'b1, 32'h8000_0000, 32'h0,         4'h0, 1'b0, 32'hCAFE_F00D};
        vecs[12] = '{1'b1, 32'h8000_1000, 32'h0,         4'h0, 1'b1, 32'h0};
`else
        vecs[10] = '{1'b0, 32'h8000_1000, 32'h0BAD_F00D, 4'hF, 1'b0, 32'h0};
        vecs[11] = '{1'b1, 32'h8000_0000, 32'h0,         4'h0, 1'b0, 32'h0BAD_F00D};
        vecs[12] = '{1'b1, 32'h8000_1000, 32'h0,         4'h0, 1'b0, 32'h0BAD_F00D};
`endif
        vecs[13] = '{1'b0, 32'h8000_0FFC, 32'h55AA_55AA, 4'hF, 1'b0, 32'h0};
        vecs[14] = '{1'b1, 32'h8000_0FFC, 32'h0,         4'h0, 1'b0, 32'h55AA_55AA};

        // Reset state, then release.
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rsp_err",   {31'b0, rsp_err},   32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        step();

        rsp_ready = 1'b1;
        for (int i = 0; i < 15; i++)
            send(vecs[i].rd, vecs[i].addr, vecs[i].wdata, vecs[i].mask, vecs[i].err, vecs[i].rdata);
        drain();

        // Latency from accept to visible response with an empty FIFO.
        send(1'b1, 32'h8000_0010, 32'h0, 4'h0, 1'b0, 32'hDEAD_BEAA);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (rsp_valid !== 1'b1 && n < 10);
        chk("rsp_latency", n - 1, LAT);
        step();
        drain();

        // Backpressure: two outstanding, third held off, head stable.
        rsp_ready = 1'b0;
        send(1'b1, 32'h8000_0010, 32'h0, 4'h0, 1'b0, 32'hDEAD_BEAA);
        send(1'b1, 32'h8000_0014, 32'h0, 4'h0, 1'b0, 32'hAA22_CC44);
        cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = 32'h8000_0000;
        repeat (3) @(negedge clk);
        chk("bp_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        chk("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("bp_head",      rsp_rdata, 32'hDEAD_BEAA);
        @(negedge clk);
        chk("bp_head_stable", rsp_rdata, 32'hDEAD_BEAA);
        step();
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        drain();

        // Accept and response handshake on the same edge at one outstanding.
        rsp_ready = 1'b0;
        send(1'b1, 32'h8000_0014, 32'h0, 4'h0, 1'b0, 32'hAA22_CC44);
        step();
        rsp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = 32'h8000_0010;
        @(negedge clk);
        chk("same_pre_ready", {31'b0, cmd_ready}, 32'd1);
        chk("same_pre_valid", {31'b0, rsp_valid}, 32'd1);
        sb.push_back('{1'b0, 32'hDEAD_BEAA});
        step();
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("same_cnt_ready", {31'b0, cmd_ready}, 32'd1);
        step();
        send(1'b1, 32'h8000_0FFC, 32'h0, 4'h0, 1'b0, 32'h55AA_55AA);
        @(negedge clk);
        chk("same_full_ready", {31'b0, cmd_ready}, 32'd0);
        step();
        rsp_ready = 1'b1;
        drain();

        // Reset with responses pending drops them but keeps memory.
        rsp_ready = 1'b0;
        send(1'b1, 32'h8000_0010, 32'h0, 4'h0, 1'b0, 32'hDEAD_BEAA);
        send(1'b1, 32'h8000_0014, 32'h0, 4'h0, 1'b0, 32'hAA22_CC44);
        step();
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_ready", {31'b0, cmd_ready}, 32'd0);
        chk("mid_rst_valid", {31'b0, rsp_valid}, 32'd0);
        step();
        step();
        sb.delete();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", {31'b0, rsp_valid}, 32'd0);
        chk("post_rst_ready", {31'b0, cmd_ready}, 32'd1);
        step();
        rsp_ready = 1'b1;
        send(1'b1, 32'h8000_0010, 32'h0, 4'h0, 1'b0, 32'hDEAD_BEAA);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
